// File: rtl/keypad_login_ctrl.sv
// rtl/keypad_login_ctrl.sv - keypad credential entry, table lookup, session grant and lockout
module keypad_login_ctrl #(
  parameter int MAX_FAIL       = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        logout,
  output logic        lookup_req,
  output logic [11:0] lookup_user,
  input  logic        lookup_ack,
  input  logic        lookup_hit,
  input  logic [15:0] lookup_pass,
  output logic        session_active,
  output logic [11:0] session_user,
  output logic        login_ok,
  output logic        login_fail,
  output logic        timeout,
  output logic        locked,
  output logic [2:0]  state
);

  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_USER   = 3'd1,
    S_PASS   = 3'd2,
    S_LOOKUP = 3'd3,
    S_GRANT  = 3'd4,
    S_DENY   = 3'd5,
    S_LOCK   = 3'd6
  } state_t;

  state_t         st;
  logic [11:0]    user_id;
  logic [15:0]    pass_reg;
  logic [1:0]     ucnt;
  logic [2:0]     pcnt;
  logic [3:0]     fail_cnt;
  logic [3:0]     fail_next;
  logic [IW-1:0]  idle_cnt;
  logic [LW-1:0]  lock_cnt;
  logic           is_digit;
  logic           is_star;
  logic           is_hash;
  logic           idle_expired;

  assign state       = st;
  assign lookup_user = user_id;
  assign is_digit    = (key_code <= 4'd9);
  assign is_star     = (key_code == 4'hA);
  assign is_hash     = (key_code == 4'hB);
  assign idle_expired = (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    fail_next = fail_cnt;
    if (fail_cnt < 4'(MAX_FAIL))
      fail_next = fail_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= S_IDLE;
      user_id        <= '0;
      pass_reg       <= '0;
      ucnt           <= '0;
      pcnt           <= '0;
      fail_cnt       <= '0;
      idle_cnt       <= '0;
      lock_cnt       <= '0;
      lookup_req     <= 1'b0;
      session_active <= 1'b0;
      session_user   <= '0;
      login_ok       <= 1'b0;
      login_fail     <= 1'b0;
      timeout        <= 1'b0;
      locked         <= 1'b0;
    end else begin
      login_ok   <= 1'b0;
      login_fail <= 1'b0;
      timeout    <= 1'b0;
      case (st)
        S_IDLE: begin
          if (key_valid && is_star) begin
            st       <= S_USER;
            user_id  <= '0;
            pass_reg <= '0;
            ucnt     <= '0;
            pcnt     <= '0;
            idle_cnt <= '0;
          end
        end
        S_USER: begin
          if (key_valid) begin
            idle_cnt <= '0;
            if (is_digit) begin
              if (ucnt < 2'd3) begin
                user_id <= {user_id[7:0], key_code};
                ucnt    <= ucnt + 2'd1;
              end
            end else if (is_hash) begin
              if (ucnt == 2'd3) begin
                st <= S_PASS;
              end else begin
                st         <= S_DENY;
                login_fail <= 1'b1;
              end
            end else if (is_star) begin
              user_id <= '0;
              ucnt    <= '0;
            end
          end else if (idle_expired) begin
            st       <= S_IDLE;
            timeout  <= 1'b1;
            user_id  <= '0;
            pass_reg <= '0;
            ucnt     <= '0;
            pcnt     <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_PASS: begin
          if (key_valid) begin
            idle_cnt <= '0;
            if (is_digit) begin
              if (pcnt < 3'd4) begin
                pass_reg <= {pass_reg[11:0], key_code};
                pcnt     <= pcnt + 3'd1;
              end
            end else if (is_hash) begin
              if (pcnt == 3'd4) begin
                st <= S_LOOKUP;
              end else begin
                st         <= S_DENY;
                login_fail <= 1'b1;
              end
            end else if (is_star) begin
              st       <= S_USER;
              user_id  <= '0;
              pass_reg <= '0;
              ucnt     <= '0;
              pcnt     <= '0;
            end
          end else if (idle_expired) begin
            st       <= S_IDLE;
            timeout  <= 1'b1;
            user_id  <= '0;
            pass_reg <= '0;
            ucnt     <= '0;
            pcnt     <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_LOOKUP: begin
          // req rises one cycle after entry and drops with the ack edge
          if (lookup_ack) begin
            lookup_req <= 1'b0;
            pass_reg   <= '0;
            if (lookup_hit && (lookup_pass == pass_reg)) begin
              st             <= S_GRANT;
              login_ok       <= 1'b1;
              session_active <= 1'b1;
              session_user   <= user_id;
              fail_cnt       <= '0;
            end else begin
              st         <= S_DENY;
              login_fail <= 1'b1;
            end
          end else begin
            lookup_req <= 1'b1;
          end
        end
        S_GRANT: begin
          if (logout) begin
            st             <= S_IDLE;
            session_active <= 1'b0;
            session_user   <= '0;
          end
        end
        S_DENY: begin
          fail_cnt <= fail_next;
          if (fail_next == 4'(MAX_FAIL)) begin
            st       <= S_LOCK;
            locked   <= 1'b1;
            lock_cnt <= '0;
          end else begin
            st <= S_IDLE;
          end
        end
        S_LOCK: begin
          if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
            st       <= S_IDLE;
            locked   <= 1'b0;
            fail_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_login_ctrl.sv
// tb/tb_keypad_login_ctrl.sv - directed bench for keypad_login_ctrl
module tb_keypad_login_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        logout = 1'b0;
  logic        lookup_req;
  logic [11:0] lookup_user;
  logic        lookup_ack = 1'b0;
  logic        lookup_hit = 1'b0;
  logic [15:0] lookup_pass = 16'h0;
  logic        session_active;
  logic [11:0] session_user;
  logic        login_ok;
  logic        login_fail;
  logic        timeout;
  logic        locked;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;

  keypad_login_ctrl #(
    .MAX_FAIL(3),
    .LOCK_CYCLES(10),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .logout(logout),
    .lookup_req(lookup_req),
    .lookup_user(lookup_user),
    .lookup_ack(lookup_ack),
    .lookup_hit(lookup_hit),
    .lookup_pass(lookup_pass),
    .session_active(session_active),
    .session_user(session_user),
    .login_ok(login_ok),
    .login_fail(login_fail),
    .timeout(timeout),
    .locked(locked),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter(input logic [11:0] u, input logic [15:0] p);
    press(4'hA);
    for (int i = 2; i >= 0; i--) press(u[i*4 +: 4]);
    press(4'hB);
    for (int i = 3; i >= 0; i--) press(p[i*4 +: 4]);
    press(4'hB);
  endtask

  task automatic wait_req();
    int n = 0;
    while (lookup_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("req_seen", 32'(lookup_req), 32'(1'b1));
  endtask

  task automatic do_ack(input logic hit, input logic [15:0] p);
    lookup_ack  = 1'b1;
    lookup_hit  = hit;
    lookup_pass = p;
    tick();
    lookup_ack  = 1'b0;
    lookup_hit  = 1'b0;
    lookup_pass = 16'h0;
  endtask

  task automatic wait_unlock();
    int n = 0;
    while (locked === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("lock_len", 32'(n), 32'd10);
    check("lock_exit_state", 32'(state), 32'd0);
  endtask

  initial begin
    int cnt;

    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_req", 32'(lookup_req), 32'd0);
    check("rst_user", 32'(lookup_user), 32'h000);
    check("rst_active", 32'(session_active), 32'd0);
    check("rst_suser", 32'(session_user), 32'h000);
    check("rst_pulses", 32'({login_ok, login_fail, timeout, locked}), 32'b0000);
    rst_n = 1'b1;
    tick();

    enter(12'h123, 16'h4567);
    check("lk_state", 32'(state), 32'd3);
    check("lk_req_first", 32'(lookup_req), 32'd0);
    wait_req();
    check("lk_user", 32'(lookup_user), 32'h123);
    do_ack(1'b1, 16'h4567);
    check("ok_state", 32'(state), 32'd4);
    check("ok_pulse", 32'(login_ok), 32'd1);
    check("ok_req_drop", 32'(lookup_req), 32'd0);
    check("ok_active", 32'(session_active), 32'd1);
    check("ok_suser", 32'(session_user), 32'h123);
    tick();
    check("ok_pulse_end", 32'(login_ok), 32'd0);
    check("ok_hold", 32'(state), 32'd4);
    logout = 1'b1;
    tick();
    logout = 1'b0;
    check("logout_state", 32'(state), 32'd0);
    check("logout_active", 32'(session_active), 32'd0);
    check("logout_suser", 32'(session_user), 32'h000);

    press(4'hA);
    press(4'h1);
    press(4'h2);
    press(4'hB);
    check("short_state", 32'(state), 32'd5);
    check("short_fail", 32'(login_fail), 32'd1);
    check("short_req", 32'(lookup_req), 32'd0);
    tick();
    check("short_idle", 32'(state), 32'd0);
    check("short_fail_end", 32'(login_fail), 32'd0);
    check("short_req2", 32'(lookup_req), 32'd0);

    press(4'hA);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    check("extra_digit_user", 32'(lookup_user), 32'h123);
    check("extra_digit_state", 32'(state), 32'd1);
    press(4'hB);
    check("pass_state", 32'(state), 32'd2);
    press(4'h4);
    press(4'h5);
    press(4'h6);
    press(4'h7);
    press(4'hB);
    wait_req();
    for (int i = 1; i < 20; i++) begin
      key_valid = (i <= 3);
      key_code  = 4'h9;
      tick();
      key_valid = 1'b0;
      check("hold_req", 32'(lookup_req), 32'd1);
      check("hold_user", 32'(lookup_user), 32'h123);
      check("hold_state", 32'(state), 32'd3);
    end
    do_ack(1'b1, 16'h0000);
    check("late_ack_state", 32'(state), 32'd5);
    check("late_ack_fail", 32'(login_fail), 32'd1);
    check("late_ack_req", 32'(lookup_req), 32'd0);
    tick();
    check("late_ack_idle", 32'(state), 32'd0);

    press(4'hA);
    press(4'h5);
    cnt = 0;
    while (timeout !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("to_latency", 32'(cnt), 32'd8);
    check("to_state", 32'(state), 32'd0);
    check("to_user_clr", 32'(lookup_user), 32'h000);
    check("to_no_fail", 32'(login_fail), 32'd0);
    tick();
    check("to_pulse_end", 32'(timeout), 32'd0);

    enter(12'h987, 16'h1111);
    wait_req();
    do_ack(1'b1, 16'h1112);
    check("wrong_pass_fail", 32'(login_fail), 32'd1);
    tick();
    check("lock_state", 32'(state), 32'd6);
    check("lock_out", 32'(locked), 32'd1);
    wait_unlock();

    for (int i = 0; i < 3; i++) begin
      enter(12'h456, 16'h4567);
      wait_req();
      if (i == 0) do_ack(1'b0, 16'h4567);
      else        do_ack(1'b1, 16'h0000);
      check("seq_fail", 32'(login_fail), 32'd1);
      check("seq_no_ok", 32'(login_ok), 32'd0);
      tick();
      check("seq_next", 32'(state), (i == 2) ? 32'd6 : 32'd0);
    end
    wait_unlock();

    do_ack(1'b1, 16'h0000);
    check("stray_ack_state", 32'(state), 32'd0);
    check("stray_ack_ok", 32'(login_ok), 32'd0);

    enter(12'h321, 16'h8765);
    wait_req();
    rst_n = 1'b0;
    tick();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_req", 32'(lookup_req), 32'd0);
    check("mid_rst_user", 32'(lookup_user), 32'h000);
    rst_n = 1'b1;
    do_ack(1'b1, 16'h8765);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_ok", 32'(login_ok), 32'd0);
    check("post_rst_active", 32'(session_active), 32'd0);
    check("post_rst_suser", 32'(session_user), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
